exe_alu: RTL and testbench
==========================

Name: exe_alu

Overview:
- Execute-stage arithmetic block of the 5-stage MIPS pipeline.
- Selects each operand through a two-level forwarding mux: EXE/MEM result first, then MEM/WB bypass, then the register-file value.
- Computes a 32-bit combinational ALU result and owns the architectural HI/LO registers used by multiply/divide and move-from/to-HI/LO.

Parameters:
- None. Widths fixed: data 32, register index 5, control 6.

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- stall  in  1  1 = hold HI/LO (cache miss).
- reg_a  in  5  source register index for operand A.
- opnd_a  in  32  register-file value of A.
- reg_b  in  5  source register index for operand B (or immediate; index 0 when immediate).
- opnd_b  in  32  register-file value or immediate for B.
- fwd1_reg  in  5  first-priority bypass destination (EXE/MEM latch).
- fwd1_data  in  32  first-priority bypass data.
- fwd1_valid  in  1  first-priority bypass valid.
- fwd2_reg  in  5  second-priority bypass destination (MEM/WB).
- fwd2_data  in  32  second-priority bypass data.
- fwd2_valid  in  1  second-priority bypass valid.
- alu_control  in  6  operation code.
- shift_amount  in  5  constant shift amount.
- alu_result  out  32  combinational result.
- a_eff, b_eff  out  32 each  operands after forwarding.
- hi, lo  out  32 each  current HI/LO register contents.

Behaviour:
- Forwarding, per operand X in {a, b}:
  - If reg_X != 0 and fwd1_valid and fwd1_reg == reg_X: X_eff = fwd1_data.
  - Else if reg_X != 0 and fwd2_valid and fwd2_reg == reg_X: X_eff = fwd2_data.
  - Else: X_eff = opnd_X.
  - Register 0 is never forwarded. Fully combinational.
- Op codes (decimal) and alu_result:
  - 1 ADD, 2 ADDU: A+B, mod 2^32, no overflow trap.
  - 3 SUB, 4 SUBU: A-B, mod 2^32, no overflow trap.
  - 5 AND, 6 OR, 7 XOR, 8 NOR.
  - 9 SLT: signed A<B -> 1, else 0.
  - 10 SLTU: unsigned A<B -> 1, else 0.
  - 11 SLL, 12 SRL, 13 SRA: B shifted by shift_amount.
  - 14 SLLV, 15 SRLV, 16 SRAV: B shifted by A[4:0].
  - 17 LUI: {B[15:0],16'h0000}.
  - 22 MFHI: hi. 23 MFLO: lo.
  - 26 PASSB: B.
  - 18–21, 24, 25, 0 and all undefined codes: result 0.
- HI/LO next state:
  - 18 MULT: {HI,LO} = signed A*B (64-bit).
  - 19 MULTU: {HI,LO} = unsigned A*B.
  - 20 DIV: LO = signed quotient, truncated toward zero; HI = remainder, sign follows dividend.
  - 21 DIVU: LO = unsigned quotient; HI = unsigned remainder.
  - DIV/DIVU with B==0: HI/LO unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - 24 MTHI: HI = A. 25 MTLO: LO = A.
  - All other codes: HI/LO unchanged.
- Timing:
  - HI/LO load next state on rising CLK when stall == 0; unchanged when stall == 1.
  - MFHI/MFLO read the registered value, so a MULT in cycle n is visible to MFLO in cycle n+1.
  - alu_result has zero latency, with no internal pipeline stage.
- Reset: RESET low asynchronously clears HI and LO to 0. alu_result, a_eff and b_eff remain combinational functions of the inputs.

Decomposition:
- Shared package exe_pkg:
  - ALU opcode localparams (ALU_ADD=6'd1 ... ALU_PASSB=6'd26).
  - Width constants DATA_W=32, REG_W=5.
- One sub-module, operand_bypass:
  - Implements the priority forwarding rule for one operand.
  - Instantiated twice, for A and B.

Test Plan:
- Forwarding priority:
  - reg_a=5, opnd_a=1, fwd1=(5, 0xAA, 1), fwd2=(5, 0xBB, 1) -> a_eff=0xAA.
  - Drop fwd1_valid -> a_eff=0xBB.
  - reg_a=0 with both bypasses matching -> a_eff=1.
- Arithmetic/compare:
  - ADD 0x7FFFFFFF+1 -> 0x80000000.
  - SUB 3-5 -> 0xFFFFFFFE.
  - SLT(-1,1) -> 1.
  - SLTU(0xFFFFFFFF,1) -> 0.
- Shifts:
  - SRA B=0x80000000, shift_amount=4 -> 0xF8000000.
  - SRLV A=4, B=0x80000000 -> 0x08000000.
  - LUI B=0x1234 -> 0x12340000.
- Multiply:
  - MULT A=-2, B=3, one clock -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Then MFLO -> alu_result=0xFFFFFFFA.
  - MULTU 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE.
- Divide:
  - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU by 0 -> hi/lo unchanged.
  - DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- Stall and reset:
  - MTHI A=0x55 with stall=1 -> hi unchanged; with stall=0 -> hi=0x55.
  - Assert RESET low mid-cycle -> hi=lo=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared constants for the execute-stage ALU: datapath widths and ALU operation codes.
package exe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [5:0] ALU_ADD   = 6'd1;
  localparam logic [5:0] ALU_ADDU  = 6'd2;
  localparam logic [5:0] ALU_SUB   = 6'd3;
  localparam logic [5:0] ALU_SUBU  = 6'd4;
  localparam logic [5:0] ALU_AND   = 6'd5;
  localparam logic [5:0] ALU_OR    = 6'd6;
  localparam logic [5:0] ALU_XOR   = 6'd7;
  localparam logic [5:0] ALU_NOR   = 6'd8;
  localparam logic [5:0] ALU_SLT   = 6'd9;
  localparam logic [5:0] ALU_SLTU  = 6'd10;
  localparam logic [5:0] ALU_SLL   = 6'd11;
  localparam logic [5:0] ALU_SRL   = 6'd12;
  localparam logic [5:0] ALU_SRA   = 6'd13;
  localparam logic [5:0] ALU_SLLV  = 6'd14;
  localparam logic [5:0] ALU_SRLV  = 6'd15;
  localparam logic [5:0] ALU_SRAV  = 6'd16;
  localparam logic [5:0] ALU_LUI   = 6'd17;
  localparam logic [5:0] ALU_MULT  = 6'd18;
  localparam logic [5:0] ALU_MULTU = 6'd19;
  localparam logic [5:0] ALU_DIV   = 6'd20;
  localparam logic [5:0] ALU_DIVU  = 6'd21;
  localparam logic [5:0] ALU_MFHI  = 6'd22;
  localparam logic [5:0] ALU_MFLO  = 6'd23;
  localparam logic [5:0] ALU_MTHI  = 6'd24;
  localparam logic [5:0] ALU_MTLO  = 6'd25;
  localparam logic [5:0] ALU_PASSB = 6'd26;

endpackage

// File: rtl/operand_bypass.sv
// Priority forwarding for one ALU operand: EXE/MEM bypass, then MEM/WB bypass, then register file.
module operand_bypass
  import exe_pkg::*;
(
  input  logic [REG_W-1:0]  reg_i,
  input  logic [DATA_W-1:0] opnd_i,
  input  logic [REG_W-1:0]  fwd1_reg_i,
  input  logic [DATA_W-1:0] fwd1_data_i,
  input  logic              fwd1_valid_i,
  input  logic [REG_W-1:0]  fwd2_reg_i,
  input  logic [DATA_W-1:0] fwd2_data_i,
  input  logic              fwd2_valid_i,
  output logic [DATA_W-1:0] eff_o
);

  logic src_nonzero;
  assign src_nonzero = (reg_i != '0);

  always_comb begin
    eff_o = opnd_i;
    if (src_nonzero && fwd1_valid_i && (fwd1_reg_i == reg_i)) begin
      eff_o = fwd1_data_i;
    end else if (src_nonzero && fwd2_valid_i && (fwd2_reg_i == reg_i)) begin
      eff_o = fwd2_data_i;
    end
  end

endmodule

// File: rtl/exe_alu.sv
// Execute-stage ALU: forwarded operands, combinational result, and the architectural HI/LO pair.
module exe_alu
  import exe_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        stall,
  input  logic [4:0]  reg_a,
  input  logic [31:0] opnd_a,
  input  logic [4:0]  reg_b,
  input  logic [31:0] opnd_b,
  input  logic [4:0]  fwd1_reg,
  input  logic [31:0] fwd1_data,
  input  logic        fwd1_valid,
  input  logic [4:0]  fwd2_reg,
  input  logic [31:0] fwd2_data,
  input  logic        fwd2_valid,
  input  logic [5:0]  alu_control,
  input  logic [4:0]  shift_amount,
  output logic [31:0] alu_result,
  output logic [31:0] a_eff,
  output logic [31:0] b_eff,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, divisor_u, divisor_s;
  logic [31:0] mag_quot, mag_rem, quot_s, rem_s, quot_u, rem_u;

  operand_bypass u_bypass_a (
    .reg_i(reg_a), .opnd_i(opnd_a),
    .fwd1_reg_i(fwd1_reg), .fwd1_data_i(fwd1_data), .fwd1_valid_i(fwd1_valid),
    .fwd2_reg_i(fwd2_reg), .fwd2_data_i(fwd2_data), .fwd2_valid_i(fwd2_valid),
    .eff_o(a_eff)
  );

  operand_bypass u_bypass_b (
    .reg_i(reg_b), .opnd_i(opnd_b),
    .fwd1_reg_i(fwd1_reg), .fwd1_data_i(fwd1_data), .fwd1_valid_i(fwd1_valid),
    .fwd2_reg_i(fwd2_reg), .fwd2_data_i(fwd2_data), .fwd2_valid_i(fwd2_valid),
    .eff_o(b_eff)
  );

  assign prod_s = $signed({{32{a_eff[31]}}, a_eff}) * $signed({{32{b_eff[31]}}, b_eff});
  assign prod_u = {32'h0, a_eff} * {32'h0, b_eff};

  // Signed divide on magnitudes; 0x80000000 / -1 then falls out as 0x80000000 rem 0.
  assign abs_a     = a_eff[31] ? (32'h0 - a_eff) : a_eff;
  assign abs_b     = b_eff[31] ? (32'h0 - b_eff) : b_eff;
  assign divisor_s = (abs_b == 32'h0) ? 32'h1 : abs_b;
  assign divisor_u = (b_eff == 32'h0) ? 32'h1 : b_eff;
  assign mag_quot  = abs_a / divisor_s;
  assign mag_rem   = abs_a % divisor_s;
  assign quot_s    = (a_eff[31] ^ b_eff[31]) ? (32'h0 - mag_quot) : mag_quot;
  assign rem_s     = a_eff[31] ? (32'h0 - mag_rem) : mag_rem;
  assign quot_u    = a_eff / divisor_u;
  assign rem_u     = a_eff % divisor_u;

  always_comb begin
    alu_result = 32'h0;
    case (alu_control)
      ALU_ADD, ALU_ADDU: alu_result = a_eff + b_eff;
      ALU_SUB, ALU_SUBU: alu_result = a_eff - b_eff;
      ALU_AND:   alu_result = a_eff & b_eff;
      ALU_OR:    alu_result = a_eff | b_eff;
      ALU_XOR:   alu_result = a_eff ^ b_eff;
      ALU_NOR:   alu_result = ~(a_eff | b_eff);
      ALU_SLT:   alu_result = {31'h0, ($signed(a_eff) < $signed(b_eff))};
      ALU_SLTU:  alu_result = {31'h0, (a_eff < b_eff)};
      ALU_SLL:   alu_result = b_eff << shift_amount;
      ALU_SRL:   alu_result = b_eff >> shift_amount;
      ALU_SRA:   alu_result = $unsigned($signed(b_eff) >>> shift_amount);
      ALU_SLLV:  alu_result = b_eff << a_eff[4:0];
      ALU_SRLV:  alu_result = b_eff >> a_eff[4:0];
      ALU_SRAV:  alu_result = $unsigned($signed(b_eff) >>> a_eff[4:0]);
      ALU_LUI:   alu_result = {b_eff[15:0], 16'h0000};
      ALU_MFHI:  alu_result = hi_q;
      ALU_MFLO:  alu_result = lo_q;
      ALU_PASSB: alu_result = b_eff;
      default:   alu_result = 32'h0;
    endcase
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    case (alu_control)
      ALU_MULT:  {hi_d, lo_d} = prod_s;
      ALU_MULTU: {hi_d, lo_d} = prod_u;
      ALU_DIV: begin
        if (b_eff != 32'h0) begin
          hi_d = rem_s;
          lo_d = quot_s;
        end
      end
      ALU_DIVU: begin
        if (b_eff != 32'h0) begin
          hi_d = rem_u;
          lo_d = quot_u;
        end
      end
      ALU_MTHI:  hi_d = a_eff;
      ALU_MTLO:  lo_d = a_eff;
      default: begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else if (!stall) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_exe_alu.sv
// Self-checking bench for exe_alu: directed corner cases, then randomized traffic against a behavioural model.
module tb_exe_alu;

  logic        CLK = 1'b0;
  logic        RESET, stall;
  logic [4:0]  reg_a, reg_b, fwd1_reg, fwd2_reg, shift_amount;
  logic [31:0] opnd_a, opnd_b, fwd1_data, fwd2_data;
  logic        fwd1_valid, fwd2_valid;
  logic [5:0]  alu_control;
  logic [31:0] alu_result, a_eff, b_eff, hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  always #5 CLK = ~CLK;

  exe_alu dut (
    .CLK(CLK), .RESET(RESET), .stall(stall),
    .reg_a(reg_a), .opnd_a(opnd_a), .reg_b(reg_b), .opnd_b(opnd_b),
    .fwd1_reg(fwd1_reg), .fwd1_data(fwd1_data), .fwd1_valid(fwd1_valid),
    .fwd2_reg(fwd2_reg), .fwd2_data(fwd2_data), .fwd2_valid(fwd2_valid),
    .alu_control(alu_control), .shift_amount(shift_amount),
    .alu_result(alu_result), .a_eff(a_eff), .b_eff(b_eff), .hi(hi), .lo(lo)
  );

  function automatic logic [31:0] fwd_model(input logic [4:0] r, input logic [31:0] v);
    if (r != 0 && fwd1_valid && fwd1_reg == r) return fwd1_data;
    if (r != 0 && fwd2_valid && fwd2_reg == r) return fwd2_data;
    return v;
  endfunction

  function automatic logic [31:0] sra_model(input logic [31:0] v, input int n);
    logic [31:0] ones = 32'hFFFF_FFFF;
    return (v >> n) | (v[31] ? ~(ones >> n) : 32'h0);
  endfunction

  function automatic logic [31:0] result_model(input int op, input logic [31:0] a, input logic [31:0] b,
                                               input int sh, input logic [31:0] h, input logic [31:0] l);
    int sv = int'(a % 32);
    case (op)
      1, 2:    return a + b;
      3, 4:    return a - b;
      5:       return a & b;
      6:       return a | b;
      7:       return a ^ b;
      8:       return ~(a | b);
      9:       return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      10:      return (a < b) ? 32'd1 : 32'd0;
      11:      return b << sh;
      12:      return b >> sh;
      13:      return sra_model(b, sh);
      14:      return b << sv;
      15:      return b >> sv;
      16:      return sra_model(b, sv);
      17:      return b * 32'h1_0000;
      22:      return h;
      23:      return l;
      26:      return b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic hilo_model(input int op, input logic [31:0] a, input logic [31:0] b);
    longint          ps;
    longint unsigned pu;
    case (op)
      18: begin ps = longint'(int'(a)) * longint'(int'(b)); {m_hi, m_lo} = ps; end
      19: begin pu = 64'(a) * 64'(b); {m_hi, m_lo} = pu; end
      20: if (b != 0) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
              m_lo = 32'h8000_0000; m_hi = 32'h0;
            end else begin
              m_lo = int'(a) / int'(b); m_hi = int'(a) % int'(b);
            end
          end
      21: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      24: m_hi = a;
      25: m_lo = a;
      default: ;
    endcase
  endtask

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_hi = 32'h0; m_lo = 32'h0;
    end else if (!stall) begin
      hilo_model(int'(alu_control), fwd_model(reg_a, opnd_a), fwd_model(reg_b, opnd_b));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [5:0] op, input logic [4:0] ra, input logic [31:0] oa,
                        input logic [4:0] rb, input logic [31:0] ob, input logic [4:0] sh);
    alu_control = op; reg_a = ra; opnd_a = oa; reg_b = rb; opnd_b = ob; shift_amount = sh;
    fwd1_valid = 1'b0; fwd2_valid = 1'b0; stall = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    check("hi_model", hi, m_hi);
    check("lo_model", lo, m_lo);
  endtask

  initial begin
    RESET = 1'b0;
    set_in(6'd0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0);
    fwd1_reg = 5'd0; fwd1_data = 32'h0; fwd2_reg = 5'd0; fwd2_data = 32'h0;
    #12;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    RESET = 1'b1;
    @(posedge CLK); #1;

    // forwarding priority
    set_in(6'd1, 5'd5, 32'h1, 5'd0, 32'h0, 5'd0);
    fwd1_reg = 5'd5; fwd1_data = 32'hAA; fwd1_valid = 1'b1;
    fwd2_reg = 5'd5; fwd2_data = 32'hBB; fwd2_valid = 1'b1;
    #1 check("fwd1_wins", a_eff, 32'hAA);
    fwd1_valid = 1'b0;
    #1 check("fwd2_fallback", a_eff, 32'hBB);
    fwd1_valid = 1'b1; reg_a = 5'd0;
    #1 check("reg0_no_fwd", a_eff, 32'h1);
    step();

    set_in(6'd1, 5'd0, 32'h7FFF_FFFF, 5'd0, 32'h1, 5'd0);  #2 check("add_ovf", alu_result, 32'h8000_0000); step();
    set_in(6'd3, 5'd0, 32'd3, 5'd0, 32'd5, 5'd0);          #2 check("sub_neg", alu_result, 32'hFFFF_FFFE); step();
    set_in(6'd9, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd1, 5'd0);  #2 check("slt", alu_result, 32'd1); step();
    set_in(6'd10, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd1, 5'd0); #2 check("sltu", alu_result, 32'd0); step();
    set_in(6'd13, 5'd0, 32'h0, 5'd0, 32'h8000_0000, 5'd4); #2 check("sra", alu_result, 32'hF800_0000); step();
    set_in(6'd15, 5'd0, 32'd4, 5'd0, 32'h8000_0000, 5'd0); #2 check("srlv", alu_result, 32'h0800_0000); step();
    set_in(6'd17, 5'd0, 32'h0, 5'd0, 32'h1234, 5'd0);      #2 check("lui", alu_result, 32'h1234_0000); step();

    set_in(6'd18, 5'd0, 32'hFFFF_FFFE, 5'd0, 32'd3, 5'd0); step();
    check("mult_hi", hi, 32'hFFFF_FFFF); check("mult_lo", lo, 32'hFFFF_FFFA);
    set_in(6'd23, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0);          #2 check("mflo", alu_result, 32'hFFFF_FFFA); step();
    set_in(6'd19, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd2, 5'd0); step();
    check("multu_hi", hi, 32'd1); check("multu_lo", lo, 32'hFFFF_FFFE);

    set_in(6'd20, 5'd0, 32'hFFFF_FFF9, 5'd0, 32'd2, 5'd0); step();
    check("div_hi", hi, 32'hFFFF_FFFF); check("div_lo", lo, 32'hFFFF_FFFD);
    set_in(6'd21, 5'd0, 32'd5, 5'd0, 32'd0, 5'd0); step();
    check("divu0_hi", hi, 32'hFFFF_FFFF); check("divu0_lo", lo, 32'hFFFF_FFFD);
    set_in(6'd20, 5'd0, 32'h8000_0000, 5'd0, 32'hFFFF_FFFF, 5'd0); step();
    check("divovf_hi", hi, 32'h0); check("divovf_lo", lo, 32'h8000_0000);

    set_in(6'd24, 5'd0, 32'h11, 5'd0, 32'h0, 5'd0); step();
    check("mthi", hi, 32'h11);
    set_in(6'd24, 5'd0, 32'h55, 5'd0, 32'h0, 5'd0); stall = 1'b1; step();
    check("mthi_stall", hi, 32'h11);
    stall = 1'b0; step();
    check("mthi_go", hi, 32'h55);

    set_in(6'd1, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0);
    #2 RESET = 1'b0;
    #1 check("async_rst_hi", hi, 32'h0);
    check("async_rst_lo", lo, 32'h0);
    RESET = 1'b1;
    step();

    for (int i = 0; i < 300; i++) begin
      alu_control  = 6'($urandom_range(0, 31));
      reg_a        = 5'($urandom_range(0, 3));
      reg_b        = 5'($urandom_range(0, 3));
      fwd1_reg     = 5'($urandom_range(0, 3));
      fwd2_reg     = 5'($urandom_range(0, 3));
      fwd1_valid   = 1'($urandom_range(0, 1));
      fwd2_valid   = 1'($urandom_range(0, 1));
      opnd_a       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      opnd_b       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      fwd1_data    = $urandom;
      fwd2_data    = $urandom;
      shift_amount = 5'($urandom_range(0, 31));
      stall        = ($urandom_range(0, 3) == 0);
      #2;
      check("rnd_a_eff", a_eff, fwd_model(reg_a, opnd_a));
      check("rnd_b_eff", b_eff, fwd_model(reg_b, opnd_b));
      check("rnd_result", alu_result,
            result_model(int'(alu_control), fwd_model(reg_a, opnd_a), fwd_model(reg_b, opnd_b),
                         int'(shift_amount), m_hi, m_lo));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
